// File: rtl/div_pkg.sv
// Shared types and constants for the iterative MIPS divider.
// Optional early-out path is enabled by DIV_EARLY_OUT_EN.
package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;
   localparam logic [DIV_WIDTH-1:0] DIV_ZERO_LO = '1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DIVZERO,
      DONE
   } divState_e;

endpackage

// File: rtl/div_iter_if.sv
// E-stage <-> divider request/result bundle.
// master: E stage / hazard side, slave: divider.
interface div_iter_if
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) ();

   logic               start;
   logic               signed_div;
   logic               annul;
   logic [WIDTH-1:0]   opdata1;
   logic [WIDTH-1:0]   opdata2;
   logic [2*WIDTH-1:0] result;
   logic               ready;

   modport master (
      output start,
      output signed_div,
      output annul,
      output opdata1,
      output opdata2,
      input  result,
      input  ready
   );

   modport slave (
      input  start,
      input  signed_div,
      input  annul,
      input  opdata1,
      input  opdata2,
      output result,
      output ready
   );

endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider for DIV/DIVU, result = {HI=rem, LO=quot}.
// Define DIV_EARLY_OUT_EN to finish trivial divisions in 2 cycles.
module div_iter
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic       clk,
   input  logic       rst,
   div_iter_if.slave  bus
);

   localparam int CW = $clog2(WIDTH) + 1;

   divState_e          state;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   dvsr;
   logic [WIDTH-1:0]   dvdRaw;
   logic               negQ;
   logic               negR;
   logic               zeroDiv;
   logic [2*WIDTH-1:0] resultQ;
   logic               readyQ;

   logic [WIDTH-1:0]   magA;
   logic [WIDTH-1:0]   magB;
   logic [WIDTH:0]     remSh;
   logic [WIDTH:0]     diff;
   logic [WIDTH-1:0]   remNx;
   logic [WIDTH-1:0]   quoNx;

   function automatic logic [2*WIDTH-1:0] fixup(
      input logic [WIDTH-1:0] q,
      input logic [WIDTH-1:0] r,
      input logic             nq,
      input logic             nr
   );
      logic [WIDTH-1:0] qs;
      logic [WIDTH-1:0] rs;
      qs = nq ? -q : q;
      rs = nr ? -r : r;
      return {rs, qs};
   endfunction

   // quo doubles as the dividend shift register; quotient bits enter at the LSB
   always_comb begin
      magA = bus.opdata1;
      magB = bus.opdata2;
      if (bus.signed_div && bus.opdata1[WIDTH-1]) magA = -bus.opdata1;
      if (bus.signed_div && bus.opdata2[WIDTH-1]) magB = -bus.opdata2;
      remSh = {rem, quo[WIDTH-1]};
      diff  = remSh - {1'b0, dvsr};
      remNx = diff[WIDTH-1:0];
      quoNx = {quo[WIDTH-2:0], 1'b1};
      if (diff[WIDTH]) begin
         remNx = remSh[WIDTH-1:0];
         quoNx = {quo[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         rem     <= '0;
         quo     <= '0;
         dvsr    <= '0;
         dvdRaw  <= '0;
         negQ    <= 1'b0;
         negR    <= 1'b0;
         zeroDiv <= 1'b0;
         resultQ <= '0;
         readyQ  <= 1'b0;
      end else if (bus.annul) begin
         state  <= IDLE;
         readyQ <= 1'b0;
      end else begin
         readyQ <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  dvdRaw  <= bus.opdata1;
                  dvsr    <= magB;
                  quo     <= magA;
                  rem     <= '0;
                  cnt     <= '0;
                  zeroDiv <= 1'b0;
                  negQ    <= bus.signed_div &
                             (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
                  negR    <= bus.signed_div & bus.opdata1[WIDTH-1];
                  if (bus.opdata2 == '0) begin
                     zeroDiv <= 1'b1;
                     state   <= DIVZERO;
                  end
`ifdef DIV_EARLY_OUT_EN
                  else if (magA < magB) begin
                     quo   <= '0;
                     rem   <= magA;
                     state <= DIVZERO;
                  end else if (magB == WIDTH'(1)) begin
                     quo   <= magA;
                     rem   <= '0;
                     state <= DIVZERO;
                  end
`endif
                  else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               rem <= remNx;
               quo <= quoNx;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  resultQ <= fixup(quoNx, remNx, negQ, negR);
                  readyQ  <= 1'b1;
                  state   <= DONE;
               end
            end
            // Immediate-finish state: divide-by-zero or a preloaded early-out
            DIVZERO: begin
               if (zeroDiv) resultQ <= {dvdRaw, {WIDTH{1'b1}}};
               else         resultQ <= fixup(quo, rem, negQ, negR);
               readyQ <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.result = resultQ;
   assign bus.ready  = readyQ;

endmodule

// File: tb/tb_div_iter.sv
// Randomized and directed bench for div_iter against an arithmetic model.
// Latency expectations follow DIV_EARLY_OUT_EN when it is defined.
module tb_div_iter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   div_iter_if #(.WIDTH(32)) bus ();

   div_iter #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

`ifdef DIV_EARLY_OUT_EN
   localparam int EOLAT = 2;
`else
   localparam int EOLAT = 33;
`endif

   // Expected {HI, LO} straight from the instruction semantics
   function automatic logic [63:0] calc(
      input logic [31:0] a,
      input logic [31:0] b,
      input bit          sg
   );
      longint    sa;
      longint    sb;
      logic [31:0] q;
      logic [31:0] r;
      if (b == 32'd0) return {a, 32'hFFFFFFFF};
      if (sg) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   function automatic int latency(
      input logic [31:0] a,
      input logic [31:0] b,
      input bit          sg
   );
      logic [31:0] ma;
      logic [31:0] mb;
      ma = (sg && a[31]) ? -a : a;
      mb = (sg && b[31]) ? -b : b;
      if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
      if (ma < mb || mb == 32'd1) return 2;
`else
      if (ma == mb + 32'd1) return 33;
`endif
      return 33;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Cycle model: countdown to completion, one DONE cycle, then idle
   int          left = 0;
   bit          doneCyc = 0;
   bit          mReady = 0;
   logic [63:0] mResult = '0;
   logic [63:0] pend = '0;

   always @(posedge clk) begin
      mReady <= 1'b0;
      if (rst) begin
         left    <= 0;
         doneCyc <= 1'b0;
         mResult <= '0;
      end else if (bus.annul) begin
         left    <= 0;
         doneCyc <= 1'b0;
      end else if (left > 0) begin
         left <= left - 1;
         if (left == 1) begin
            mReady  <= 1'b1;
            mResult <= pend;
            doneCyc <= 1'b1;
         end
      end else if (doneCyc) begin
         doneCyc <= 1'b0;
      end else if (bus.start) begin
         left <= latency(bus.opdata1, bus.opdata2, bus.signed_div) - 1;
         pend <= calc(bus.opdata1, bus.opdata2, bus.signed_div);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("mon ready", 64'(bus.ready), 64'(mReady));
         chk("mon result", bus.result, mResult);
      end
   end

   task automatic runOp(
      input logic [31:0] a,
      input logic [31:0] b,
      input bit          sg,
      input logic [63:0] exp,
      input int          expLat,
      input bit          sync,
      input bit          keep,
      input string       nm
   );
      int n;
      bit got;
      if (sync) @(negedge clk);
      bus.opdata1    = a;
      bus.opdata2    = b;
      bus.signed_div = sg;
      bus.start      = 1'b1;
      n   = 0;
      got = 0;
      while (!got && n < 100) begin
         @(negedge clk);
         n++;
         got = bus.ready;
      end
      chk({nm, " lat"}, 64'(n), 64'(expLat));
      chk({nm, " res"}, bus.result, exp);
      chk({nm, " model"}, calc(a, b, sg), exp);
      if (!keep) bus.start = 1'b0;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFFFFFF;
         3:       return 32'h80000000;
         4:       return 32'($urandom_range(0, 15));
         5:       return 32'($urandom_range(0, 1000));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n;
      int abortAt;
      int seen;
      bus.start      = 1'b0;
      bus.signed_div = 1'b0;
      bus.annul      = 1'b0;
      bus.opdata1    = '0;
      bus.opdata2    = '0;
      repeat (3) @(negedge clk);
      chk("reset ready", 64'(bus.ready), 64'd0);
      chk("reset result", bus.result, 64'd0);
      rst = 1'b0;

      runOp(32'd7, 32'd2, 1'b0, 64'h00000001_00000003, 33, 1, 0, "divu 7/2");
      runOp(32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, 1, 0,
            "div -7/2");
      runOp(32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 33, 1, 0,
            "div 7/-2");
      runOp(32'h12345678, 32'd0, 1'b0, 64'h12345678_FFFFFFFF, 2, 1, 0,
            "divzero");
      runOp(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, EOLAT,
            1, 0, "overflow");
      runOp(32'd3, 32'd10, 1'b0, 64'h00000003_00000000, EOLAT, 1, 0,
            "3/10");
      runOp(32'h55, 32'd1, 1'b0, 64'h00000000_00000055, EOLAT, 1, 0,
            "0x55/1");

      // Abort in the middle of a division
      @(negedge clk);
      bus.opdata1    = 32'h1000;
      bus.opdata2    = 32'd3;
      bus.signed_div = 1'b0;
      bus.start      = 1'b1;
      repeat (11) @(negedge clk);
      bus.annul = 1'b1;
      bus.start = 1'b0;
      @(negedge clk);
      bus.annul = 1'b0;
      chk("annul ready", 64'(bus.ready), 64'd0);
      chk("annul result", bus.result, 64'h00000000_00000055);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.ready) seen++;
      end
      chk("annul no ready", 64'(seen), 64'd0);

      // Back-to-back with start held across DONE
      runOp(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 1, 1, "b2b 1");
      runOp(32'hFFFFFFFF, 32'h10, 1'b0, 64'h0000000F_0FFFFFFF, 34, 0, 0,
            "b2b 2");

      for (int k = 0; k < 120; k++) begin
         @(negedge clk);
         bus.opdata1    = pick();
         bus.opdata2    = pick();
         bus.signed_div = 1'($urandom_range(0, 1));
         bus.start      = 1'b1;
         abortAt = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 30) : 0;
         n = 0;
         while (n < 100) begin
            if (n == abortAt && n > 0) begin
               bus.annul = 1'b1;
               bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
            if (bus.annul) begin
               bus.annul = 1'b0;
               break;
            end
            if (bus.ready) break;
            if (n == 1) begin
               if ($urandom_range(0, 1) == 1) bus.start = 1'b0;
               bus.opdata1 = $urandom;
               bus.opdata2 = $urandom;
            end
         end
         if (n >= 100) chk("random timeout", 64'(n), 64'd0);
         bus.start = 1'b0;
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative radix-2 restoring divider for MIPS DIV/DIVU, located in the execute stage.
- Produces the {HI, LO} pair that the M/W-stage HI/LO writeback consumes.
- Drives the ready flag that the hazard unit combines with the E-stage start to stall F/D/E.
- A pipeline flush on exception aborts any division in flight.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  division request from E stage (StartDivE); held high while E is stalled.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU.
- annul  in  1  exception flush (ExceptSignal); aborts current operation.
- opdata1  in  WIDTH  dividend (rs).
- opdata2  in  WIDTH  divisor (rt).
- result  out  2*WIDTH  {remainder → HI, quotient → LO}.
- ready  out  1  result valid (DivReadyE); one-cycle pulse.

Behaviour:
- Reset: synchronous, active-high.
  - State IDLE, result = 0, ready = 0, counter = 0.
  - Reset mid-operation discards all work.
- States:
  - IDLE: start & ~annul → capture operand magnitudes and sign flags.
    - If divisor = 0 → DIVZERO.
    - Otherwise → BUSY, with counter = 0.
  - BUSY: one quotient bit per cycle, MSB first.
    - 33-bit partial remainder: shift in the next dividend bit, trial-subtract the divisor magnitude.
    - Non-negative → keep the difference and set quotient bit 1; negative → restore and set bit 0.
    - Counter increments each cycle; after WIDTH iterations → DONE.
  - DIVZERO: result = {opdata1, {WIDTH{1'b1}}}, i.e. HI = dividend, LO = all ones → DONE.
  - DONE: ready = 1 for exactly one cycle; apply sign fix-up into result → IDLE.
- Latency: ready is high WIDTH+1 cycles after the first cycle start is sampled in IDLE (33 for WIDTH=32). Divide-by-zero takes 2 cycles.
- Sign rules (signed_div=1):
  - Magnitudes are used internally.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
  - Signed overflow −2^(W−1) / −1 gives LO = 0x80000000, HI = 0 (wraps; no trap).
- Operands are latched at IDLE→BUSY; later input changes are ignored until the next start.
- Result holds its value after DONE until the next completion (it does not clear in IDLE).
- annul in any state → IDLE next cycle, ready = 0, result unchanged. annul has priority over start and over DONE.
- start low during BUSY does not abort; only annul or rst aborts.
- Back-to-back: start still high in the IDLE cycle after DONE begins a new division with the current operands, since the E stage has advanced to the next instruction.
- ready is never asserted outside DONE.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined:
  - In IDLE, if |dividend| < |divisor| (divisor ≠ 0), go directly to DONE with quotient 0 and remainder = dividend. This takes 2 cycles.
  - Also, if the divisor magnitude is 1, go to DONE with quotient = signed-adjusted dividend and remainder 0.
- Undefined: every nonzero-divisor operation takes the full WIDTH+1 cycles. Results are identical either way; only latency differs.

Decomposition:
- Package div_pkg holds:
  - the state encoding (IDLE, BUSY, DIVZERO, DONE);
  - DIV_WIDTH = 32;
  - the divide-by-zero LO constant (all ones);
  - the counter width, clog2(WIDTH)+1.
- Single module; the sign fix-up is a local function, no sub-module.

Test Plan:
- DIVU 7/2: start=1 held → ready pulses at cycle 33 with result = {HI=0x00000001, LO=0x00000003}; ready=0 at cycles 1–32.
- DIV −7/2 (0xFFFFFFF9/0x00000002) → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 7/−2 → LO=0xFFFFFFFD, HI=0x00000001.
- Divisor 0, dividend 0x12345678 → ready at cycle 2, HI=0x12345678, LO=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- annul at cycle 10 of BUSY → ready stays 0, state IDLE next cycle, result retains the previous value. A new start then completes normally in 33 cycles.
- Back-to-back: 100/7 then start kept high with 0xFFFFFFFF/0x10 unsigned → ready at 33 (LO=14, HI=2), then at 67 (LO=0x0FFFFFFF, HI=0xF).
- With DIV_EARLY_OUT_EN: 3/10 → ready at cycle 2, LO=0, HI=3; 0x55/1 → LO=0x55, HI=0 at cycle 2. Without the macro, both complete at cycle 33 with the same values.
